// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and the 32-bit datapath bus.
// master: the result stage (accepts ALU results, drives bus beats).
// slave : the surrounding environment (ALU producer plus bus consumer).
interface alu_result_stage_if #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 13
);
    // ALU result side
    logic [SIG_COUNT-1:0] ctrl_signal;
    logic [2*BITS-1:0]    op_result;
    logic                 res_valid;
    logic                 res_ready;
    // Datapath bus side
    logic [BITS-1:0]      bus_data;
    logic                 bus_valid;
    logic                 bus_ready;
    logic                 bus_last;

    modport master (
        input  ctrl_signal,
        input  op_result,
        input  res_valid,
        output res_ready,
        output bus_data,
        output bus_valid,
        input  bus_ready,
        output bus_last
    );

    modport slave (
        output ctrl_signal,
        output op_result,
        output res_valid,
        input  res_ready,
        input  bus_data,
        input  bus_valid,
        output bus_ready,
        input  bus_last
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures the ALU's 2*BITS-wide result and serialises it onto
// the BITS-wide bus (one beat for narrow ops, low then high beat for MUL/DIV).
// Updates HI/LO when the last beat of a wide op is accepted.
// Optional feature macro: ALU_RESULT_BYPASS_EN -- accept the next result during
// the final beat so narrow results stream at one per cycle.
module alu_result_stage #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 13,
    parameter int MUL_BIT   = 2,
    parameter int DIV_BIT   = 3
) (
    input  logic                  clk,
    input  logic                  clr,
    alu_result_stage_if.master    io,
    output logic [BITS-1:0]       hi_out,
    output logic [BITS-1:0]       lo_out,
    output logic                  op_err,
    output logic                  busy
);

`ifdef ALU_RESULT_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE_LO = 2'd1,
        DRIVE_HI = 2'd2
    } state_t;

    // True when exactly one op-select bit is set.
    function automatic logic is_one_hot(input logic [SIG_COUNT-1:0] v);
        logic [SIG_COUNT-1:0] v_minus_one;
        v_minus_one = v - {{(SIG_COUNT-1){1'b0}}, 1'b1};
        return (v != {SIG_COUNT{1'b0}}) && ((v & v_minus_one) == {SIG_COUNT{1'b0}});
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [2*BITS-1:0]   z_r;
    logic [2*BITS-1:0]   z_next_s;
    logic                wide_r;
    logic                wide_next_s;
    logic [BITS-1:0]     hi_r;
    logic [BITS-1:0]     lo_r;
    logic                op_err_r;

    logic                res_ready_r;
    logic [BITS-1:0]     bus_data_r;
    logic                bus_valid_r;
    logic                bus_last_r;
    logic                busy_r;

    logic                res_ready_nx_s;
    logic [BITS-1:0]     bus_data_nx_s;
    logic                bus_valid_nx_s;
    logic                bus_last_nx_s;
    logic                busy_nx_s;

    logic                capture_s;
    logic                hi_done_s;

    // While a final beat is on the bus, a new result is only taken if that beat completes.
    assign capture_s = io.res_valid && res_ready_r && ((state_r == IDLE) || io.bus_ready);
    assign hi_done_s = (state_r == DRIVE_HI) && io.bus_ready;

    assign z_next_s    = capture_s ? io.op_result : z_r;
    assign wide_next_s = capture_s ? (io.ctrl_signal[MUL_BIT] | io.ctrl_signal[DIV_BIT]) : wide_r;

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: advance on bus acceptance, optionally chain straight into a new capture.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    next_state_s = DRIVE_LO;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRIVE_LO: begin
                if (!io.bus_ready) begin
                    next_state_s = DRIVE_LO;
                end else if (wide_r) begin
                    next_state_s = DRIVE_HI;
                end else if (capture_s) begin
                    next_state_s = DRIVE_LO;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRIVE_HI: begin
                if (!io.bus_ready) begin
                    next_state_s = DRIVE_HI;
                end else if (capture_s) begin
                    next_state_s = DRIVE_LO;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode for the coming cycle, derived from the next state and next captured result.
    always_comb begin
        res_ready_nx_s = 1'b0;
        bus_data_nx_s  = {BITS{1'b0}};
        bus_valid_nx_s = 1'b0;
        bus_last_nx_s  = 1'b0;
        busy_nx_s      = 1'b0;
        case (next_state_s)
            IDLE: begin
                res_ready_nx_s = 1'b1;
            end
            DRIVE_LO: begin
                bus_valid_nx_s = 1'b1;
                bus_data_nx_s  = z_next_s[BITS-1:0];
                bus_last_nx_s  = !wide_next_s;
                res_ready_nx_s = BYPASS && !wide_next_s;
                busy_nx_s      = 1'b1;
            end
            DRIVE_HI: begin
                bus_valid_nx_s = 1'b1;
                bus_data_nx_s  = z_next_s[2*BITS-1:BITS];
                bus_last_nx_s  = 1'b1;
                res_ready_nx_s = BYPASS;
                busy_nx_s      = 1'b1;
            end
            default: begin
                res_ready_nx_s = 1'b0;
            end
        endcase
    end

    // Registered handshake/bus outputs; clr drops them at once so an aborted beat vanishes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            res_ready_r <= 1'b1;
            bus_data_r  <= {BITS{1'b0}};
            bus_valid_r <= 1'b0;
            bus_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            res_ready_r <= res_ready_nx_s;
            bus_data_r  <= bus_data_nx_s;
            bus_valid_r <= bus_valid_nx_s;
            bus_last_r  <= bus_last_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    // Result capture, HI/LO commit on the final wide beat, and sticky op-select error.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            z_r      <= {(2*BITS){1'b0}};
            wide_r   <= 1'b0;
            hi_r     <= {BITS{1'b0}};
            lo_r     <= {BITS{1'b0}};
            op_err_r <= 1'b0;
        end else begin
            z_r    <= z_next_s;
            wide_r <= wide_next_s;
            if (hi_done_s) begin
                hi_r <= z_r[2*BITS-1:BITS];
                lo_r <= z_r[BITS-1:0];
            end
            if (capture_s && !is_one_hot(io.ctrl_signal)) begin
                op_err_r <= 1'b1;
            end
        end
    end

    assign io.res_ready = res_ready_r;
    assign io.bus_data  = bus_data_r;
    assign io.bus_valid = bus_valid_r;
    assign io.bus_last  = bus_last_r;
    assign busy         = busy_r;
    assign hi_out       = hi_r;
    assign lo_out       = lo_r;
    assign op_err       = op_err_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: expected beats are queued when a result is
// captured and compared as the bus accepts them.
module tb_alu_result_stage;

    localparam logic [12:0] ADD = 13'h0001;
    localparam logic [12:0] MUL = 13'h0004;
    localparam logic [12:0] DIV = 13'h0008;
`ifdef ALU_RESULT_BYPASS_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    logic        clk;
    logic        clr;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        op_err;
    logic        busy;

    alu_result_stage_if #(.BITS(32), .SIG_COUNT(13)) bus_if ();

    alu_result_stage #(.BITS(32), .SIG_COUNT(13), .MUL_BIT(2), .DIV_BIT(3)) dut (
        .clk    (clk),
        .clr    (clr),
        .io     (bus_if),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .op_err (op_err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    logic        acc_seen;
    logic [32:0] exp_q[$];   // {data, last}
    int          beat_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: observe handshakes just before the edge, then step past it.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        acc_seen = bus_if.res_valid && bus_if.res_ready && (!busy || bus_if.bus_ready);
        if (bus_if.bus_valid && bus_if.bus_ready) begin
            beat_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("spurious_beat_qsize", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 64'(bus_if.bus_data), 64'(e[32:1]));
                check("beat_last", 64'(bus_if.bus_last), 64'(e[0]));
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic send(input logic [12:0] c, input logic [63:0] r, input bit keep);
        bit got;
        bit wide;
        got  = 1'b0;
        wide = c[2] | c[3];
        bus_if.ctrl_signal = c;
        bus_if.op_result   = r;
        bus_if.res_valid   = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = acc_seen;
        end
        check("capture_accepted", 64'(got), 64'd1);
        if (got) begin
            exp_q.push_back({r[31:0], !wide});
            if (wide) exp_q.push_back({r[63:32], 1'b1});
        end
        if (!keep) bus_if.res_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || busy); i++) tick();
        check("drain_complete", 64'(exp_q.size() == 0 && !busy), 64'd1);
    endtask

    initial begin
        clr                = 1'b1;
        bus_if.ctrl_signal = 13'h0000;
        bus_if.op_result   = 64'h0;
        bus_if.res_valid   = 1'b0;
        bus_if.bus_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check("rst_bus_valid", 64'(bus_if.bus_valid), 64'd0);
        check("rst_bus_last",  64'(bus_if.bus_last),  64'd0);
        check("rst_bus_data",  64'(bus_if.bus_data),  64'd0);
        check("rst_res_ready", 64'(bus_if.res_ready), 64'd1);
        check("rst_busy",      64'(busy),             64'd0);
        check("rst_op_err",    64'(op_err),           64'd0);
        check("rst_hi",        64'(hi_out),           64'd0);
        check("rst_lo",        64'(lo_out),           64'd0);

        // 1: narrow ADD, single beat, HI/LO untouched
        bus_if.bus_ready = 1'b1;
        send(ADD, 64'd20, 1'b0);
        check("add_first_beat_valid", 64'(bus_if.bus_valid), 64'd1);
        drain();
        check("add_hi_unchanged", 64'(hi_out), 64'd0);
        check("add_lo_unchanged", 64'(lo_out), 64'd0);

        // 2: MUL of -75, two beats then HI/LO commit
        send(MUL, 64'hFFFFFFFF_FFFFFFB5, 1'b0);
        drain();
        check("mul_lo", 64'(lo_out), 64'hFFFFFFB5);
        check("mul_hi", 64'(hi_out), 64'hFFFFFFFF);

        // 3: DIV with bus stalled for three cycles in the low beat
        bus_if.bus_ready = 1'b0;
        send(DIV, {32'd0, 32'hFFFFFFFD}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("div_stall_valid", 64'(bus_if.bus_valid), 64'd1);
            check("div_stall_data",  64'(bus_if.bus_data),  64'hFFFFFFFD);
            check("div_stall_last",  64'(bus_if.bus_last),  64'd0);
            tick();
        end
        bus_if.bus_ready = 1'b1;
        drain();
        check("div_lo", 64'(lo_out), 64'hFFFFFFFD);
        check("div_hi", 64'(hi_out), 64'h0);

        // 4: two-hot select flags op_err, transfer still completes, error stays sticky
        send(13'h0003, 64'd5, 1'b0);
        check("err_set", 64'(op_err), 64'd1);
        drain();
        send(ADD, 64'd7, 1'b0);
        drain();
        check("err_sticky", 64'(op_err), 64'd1);
        check("err_hi_unchanged", 64'(hi_out), 64'h0);
        check("err_lo_unchanged", 64'(lo_out), 64'hFFFFFFFD);

        // 5: clr while the MUL high beat is pending
        bus_if.bus_ready = 1'b0;
        send(MUL, 64'h00000012_00000034, 1'b0);
        bus_if.bus_ready = 1'b1;
        tick();                      // low beat accepted here
        bus_if.bus_ready = 1'b0;     // now sitting in the high beat
        check("abort_in_hi_valid", 64'(bus_if.bus_valid), 64'd1);
        check("abort_in_hi_data",  64'(bus_if.bus_data),  64'h12);
        #1 clr = 1'b1;
        #1;
        check("abort_bus_valid", 64'(bus_if.bus_valid), 64'd0);
        check("abort_busy",      64'(busy),             64'd0);
        check("abort_hi",        64'(hi_out),           64'd0);
        check("abort_lo",        64'(lo_out),           64'd0);
        check("abort_op_err",    64'(op_err),           64'd0);
        check("abort_pending_beats", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        #1 clr = 1'b0;
        bus_if.bus_ready = 1'b1;
        send(ADD, 64'd9, 1'b0);
        drain();
        check("post_abort_hi", 64'(hi_out), 64'd0);
        check("post_abort_lo", 64'(lo_out), 64'd0);

        // 6: three ADDs with res_valid and bus_ready held high
        beat_cyc.delete();
        send(ADD, 64'd1, 1'b1);
        send(ADD, 64'd2, 1'b1);
        send(ADD, 64'd3, 1'b0);
        drain();
        check("b2b_beat_count", 64'(beat_cyc.size()), 64'd3);
        if (beat_cyc.size() == 3) begin
            check("b2b_gap_1", 64'(beat_cyc[1] - beat_cyc[0]), 64'(EXP_GAP));
            check("b2b_gap_2", 64'(beat_cyc[2] - beat_cyc[1]), 64'(EXP_GAP));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
